// File: rtl/au_pkg.sv
// Shared definitions for the AU reservation station and the AU itself:
// operand widths, execute_type encodings and the station entry layout.
package au_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam int OP_W  = 5;

    typedef enum logic [OP_W-1:0] {
        AU_ADD  = 5'd0,
        AU_SUB  = 5'd1,
        AU_AND  = 5'd2,
        AU_OR   = 5'd3,
        AU_XOR  = 5'd4,
        AU_SLL  = 5'd5,
        AU_SRL  = 5'd6,
        AU_SRA  = 5'd7,
        AU_SLT  = 5'd8,
        AU_SLTU = 5'd9
    } au_op_e;

    typedef struct packed {
        logic             rdy;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } rs_src_t;

    typedef struct packed {
        logic             valid;
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] dst_tag;
        rs_src_t          src1;
        rs_src_t          src2;
    } rs_entry_t;

    // A waiting source whose producer tag is on the CDB takes the broadcast value.
    function automatic rs_src_t capture_src(input rs_src_t          s,
                                            input logic             cdbValid,
                                            input logic [TAG_W-1:0] cdbTag,
                                            input logic [XLEN-1:0]  cdbData);
        rs_src_t r;
        r = s;
        if (!s.rdy && cdbValid && (s.tag == cdbTag)) begin
            r.rdy = 1'b1;
            r.val = cdbData;
        end
        return r;
    endfunction

endpackage

// File: rtl/au_rs_select.sv
// Oldest-ready picker: entries are age ordered, so the lowest index whose
// both operands are present wins.
import au_pkg::*;

module au_rs_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]         ready_i,
    output logic                     found_o,
    output logic [$clog2(DEPTH)-1:0] idx_o
);

    // Scan from the youngest down so the oldest ready entry is the last one written.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_i[i]) begin
                found_o = 1'b1;
                idx_o   = ($clog2(DEPTH))'(i);
            end
        end
    end

endmodule

// File: rtl/au_rs.sv
// Reservation station feeding the integer AU. Buffers dispatched micro-ops in
// age order, snoops the CDB for missing operands and issues the oldest ready
// op through a registered valid/ready output stage.
import au_pkg::*;

module au_rs #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [OP_W-1:0]  disp_op,
    input  logic [TAG_W-1:0] disp_dst_tag,
    input  logic             disp_src1_rdy,
    input  logic             disp_src2_rdy,
    input  logic [TAG_W-1:0] disp_src1_tag,
    input  logic [TAG_W-1:0] disp_src2_tag,
    input  logic [XLEN-1:0]  disp_src1_val,
    input  logic [XLEN-1:0]  disp_src2_val,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic             issue_valid,
    input  logic             au_ready,
    output logic [XLEN-1:0]  operand1,
    output logic [XLEN-1:0]  operand2,
    output logic [OP_W-1:0]  execute_type,
    output logic [TAG_W-1:0] issue_tag
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rs_entry_t        entries_q [DEPTH];
    rs_entry_t        entries_d [DEPTH];
    rs_entry_t        woken     [DEPTH];
    rs_entry_t        newEntry;
    rs_src_t          newSrc1;
    rs_src_t          newSrc2;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] writeIdx;
    logic             dispReady_q, dispReady_d;
    logic             issueValid_q, issueValid_d;
    logic [XLEN-1:0]  operand1_q, operand1_d;
    logic [XLEN-1:0]  operand2_q, operand2_d;
    logic [OP_W-1:0]  execType_q, execType_d;
    logic [TAG_W-1:0] issueTag_q, issueTag_d;
    logic [DEPTH-1:0] entryReady;
    logic             selFound;
    logic [IDX_W-1:0] selIdx;
    logic             advance;
    logic             doIssue;
    logic             doDisp;

    // Eligibility comes from registered state only, so a fresh wakeup waits a cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entryReady[i] = entries_q[i].valid && entries_q[i].src1.rdy && entries_q[i].src2.rdy;
        end
    end

    au_rs_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .ready_i (entryReady),
        .found_o (selFound),
        .idx_o   (selIdx)
    );

    // Apply this cycle's CDB broadcast to every waiting source of every live entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = entries_q[i];
            if (entries_q[i].valid) begin
                woken[i].src1 = capture_src(entries_q[i].src1, cdb_valid, cdb_tag, cdb_data);
                woken[i].src2 = capture_src(entries_q[i].src2, cdb_valid, cdb_tag, cdb_data);
            end
        end
    end

    // Next state: collapse out the issued entry, append the dispatch behind the
    // survivors, update the output stage; flush discards all of it.
    always_comb begin
        advance = !issueValid_q || au_ready;
        doIssue = advance && selFound;
        doDisp  = disp_valid && dispReady_q;

        newSrc1.rdy = disp_src1_rdy;
        newSrc1.tag = disp_src1_tag;
        newSrc1.val = disp_src1_rdy ? disp_src1_val : '0;
        newSrc2.rdy = disp_src2_rdy;
        newSrc2.tag = disp_src2_tag;
        newSrc2.val = disp_src2_rdy ? disp_src2_val : '0;

        newEntry.valid   = 1'b1;
        newEntry.op      = disp_op;
        newEntry.dst_tag = disp_dst_tag;
        newEntry.src1    = capture_src(newSrc1, cdb_valid, cdb_tag, cdb_data);
        newEntry.src2    = capture_src(newSrc2, cdb_valid, cdb_tag, cdb_data);

        for (int i = 0; i < DEPTH - 1; i++) begin
            if (doIssue && (int'(selIdx) <= i)) begin
                entries_d[i] = woken[i + 1];
            end else begin
                entries_d[i] = woken[i];
            end
        end
        entries_d[DEPTH - 1] = doIssue ? '0 : woken[DEPTH - 1];

        writeIdx = count_q - CNT_W'(doIssue);
        for (int i = 0; i < DEPTH; i++) begin
            if (doDisp && (int'(writeIdx) == i)) begin
                entries_d[i] = newEntry;
            end
        end

        count_d = count_q + CNT_W'(doDisp) - CNT_W'(doIssue);

        issueValid_d = issueValid_q;
        operand1_d   = operand1_q;
        operand2_d   = operand2_q;
        execType_d   = execType_q;
        issueTag_d   = issueTag_q;
        if (advance) begin
            if (selFound) begin
                issueValid_d = 1'b1;
                operand1_d   = entries_q[selIdx].src1.val;
                operand2_d   = entries_q[selIdx].src2.val;
                execType_d   = entries_q[selIdx].op;
                issueTag_d   = entries_q[selIdx].dst_tag;
            end else begin
                issueValid_d = 1'b0;
            end
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            count_d      = '0;
            issueValid_d = 1'b0;
        end

        dispReady_d = (count_d < CNT_W'(DEPTH));
    end

    // State and output registers; dispatch ready is registered from the next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q      <= '0;
            dispReady_q  <= 1'b1;
            issueValid_q <= 1'b0;
            operand1_q   <= '0;
            operand2_q   <= '0;
            execType_q   <= '0;
            issueTag_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q      <= count_d;
            dispReady_q  <= dispReady_d;
            issueValid_q <= issueValid_d;
            operand1_q   <= operand1_d;
            operand2_q   <= operand2_d;
            execType_q   <= execType_d;
            issueTag_q   <= issueTag_d;
        end
    end

    assign disp_ready   = dispReady_q;
    assign issue_valid  = issueValid_q;
    assign operand1     = operand1_q;
    assign operand2     = operand2_q;
    assign execute_type = execType_q;
    assign issue_tag    = issueTag_q;

endmodule

// File: tb/tb_au_rs.sv
// Directed testbench for the AU reservation station.
module tb_au_rs;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [4:0]  disp_op;
    logic [3:0]  disp_dst_tag;
    logic        disp_src1_rdy;
    logic        disp_src2_rdy;
    logic [3:0]  disp_src1_tag;
    logic [3:0]  disp_src2_tag;
    logic [31:0] disp_src1_val;
    logic [31:0] disp_src2_val;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        issue_valid;
    logic        au_ready;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [4:0]  execute_type;
    logic [3:0]  issue_tag;

    int total;
    int bad;

    au_rs #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_op       (disp_op),
        .disp_dst_tag  (disp_dst_tag),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .disp_src1_tag (disp_src1_tag),
        .disp_src2_tag (disp_src2_tag),
        .disp_src1_val (disp_src1_val),
        .disp_src2_val (disp_src2_val),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .issue_valid   (issue_valid),
        .au_ready      (au_ready),
        .operand1      (operand1),
        .operand2      (operand2),
        .execute_type  (execute_type),
        .issue_tag     (issue_tag)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush         = 1'b0;
        disp_valid    = 1'b0;
        disp_op       = '0;
        disp_dst_tag  = '0;
        disp_src1_rdy = 1'b0;
        disp_src2_rdy = 1'b0;
        disp_src1_tag = '0;
        disp_src2_tag = '0;
        disp_src1_val = '0;
        disp_src2_val = '0;
        cdb_valid     = 1'b0;
        cdb_tag       = '0;
        cdb_data      = '0;
    endtask

    task automatic set_disp(input logic [4:0] op, input logic [3:0] dst,
                            input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                            input logic r2, input logic [3:0] t2, input logic [31:0] v2);
        disp_valid    = 1'b1;
        disp_op       = op;
        disp_dst_tag  = dst;
        disp_src1_rdy = r1;
        disp_src1_tag = t1;
        disp_src1_val = v1;
        disp_src2_rdy = r2;
        disp_src2_tag = t2;
        disp_src2_val = v2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        au_ready = 1'b1;
        idle_inputs();
        tick();
        tick();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_issue_valid got=%b exp=0", issue_valid); end
        total++; if (disp_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_disp_ready got=%b exp=1", disp_ready); end
        total++; if (operand1 !== 32'd0 || operand2 !== 32'd0) begin bad++; $display("[TB] FAIL reset_operands got=%h/%h exp=0/0", operand1, operand2); end
        total++; if (execute_type !== 5'd0 || issue_tag !== 4'd0) begin bad++; $display("[TB] FAIL reset_type_tag got=%h/%h exp=0/0", execute_type, issue_tag); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ready_dispatch();
        au_ready = 1'b1;
        set_disp(5'd0, 4'd3, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 32'd5);
        tick();
        idle_inputs();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL ready_early got=%b exp=0", issue_valid); end
        tick();
        total++; if (issue_valid !== 1'b1) begin bad++; $display("[TB] FAIL ready_valid got=%b exp=1", issue_valid); end
        total++; if (operand1 !== 32'd7 || operand2 !== 32'd5) begin bad++; $display("[TB] FAIL ready_operands got=%h/%h exp=7/5", operand1, operand2); end
        total++; if (issue_tag !== 4'd3 || execute_type !== 5'd0) begin bad++; $display("[TB] FAIL ready_tag_type got=%h/%h exp=3/0", issue_tag, execute_type); end
        tick();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL ready_one_cycle got=%b exp=0", issue_valid); end
    endtask

    task automatic test_cdb_wakeup();
        au_ready = 1'b1;
        set_disp(5'd1, 4'd6, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd1);
        tick();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL cdb_wait_%0d got=%b exp=0", k, issue_valid); end
            tick();
        end
        cdb_valid = 1'b1;
        cdb_tag   = 4'd9;
        cdb_data  = 32'hDEAD;
        tick();
        idle_inputs();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL cdb_too_early got=%b exp=0", issue_valid); end
        tick();
        total++; if (issue_valid !== 1'b1) begin bad++; $display("[TB] FAIL cdb_valid got=%b exp=1", issue_valid); end
        total++; if (operand1 !== 32'hDEAD || operand2 !== 32'd1) begin bad++; $display("[TB] FAIL cdb_operands got=%h/%h exp=dead/1", operand1, operand2); end
        total++; if (issue_tag !== 4'd6 || execute_type !== 5'd1) begin bad++; $display("[TB] FAIL cdb_tag_type got=%h/%h exp=6/1", issue_tag, execute_type); end
        tick();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL cdb_drain got=%b exp=0", issue_valid); end
    endtask

    task automatic test_full_backpressure();
        au_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++; if (disp_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_ready_%0d got=%b exp=1", k, disp_ready); end
            set_disp(5'(k + 2), 4'(k + 1), 1'b1, 4'd0, 32'(10 + k), 1'b1, 4'd0, 32'(20 + k));
            tick();
        end
        total++; if (disp_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_not_ready got=%b exp=0", disp_ready); end
        total++; if (issue_valid !== 1'b1 || operand1 !== 32'd10 || issue_tag !== 4'd1) begin bad++; $display("[TB] FAIL full_head got=%b/%h/%h exp=1/a/1", issue_valid, operand1, issue_tag); end
        set_disp(5'd9, 4'd15, 1'b1, 4'd0, 32'd99, 1'b1, 4'd0, 32'd98);
        tick();
        total++; if (operand1 !== 32'd10 || operand2 !== 32'd20 || execute_type !== 5'd2) begin bad++; $display("[TB] FAIL full_hold got=%h/%h/%h exp=a/14/2", operand1, operand2, execute_type); end
        total++; if (disp_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_still_full got=%b exp=0", disp_ready); end
        idle_inputs();
        au_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            total++; if (issue_valid !== 1'b1 || operand1 !== 32'(10 + k) || operand2 !== 32'(20 + k) || issue_tag !== 4'(k + 1)) begin
                bad++; $display("[TB] FAIL drain_%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", k, issue_valid, operand1, operand2, issue_tag, 10 + k, 20 + k, k + 1);
            end
        end
        tick();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_empty got=%b exp=0", issue_valid); end
        total++; if (disp_ready !== 1'b1) begin bad++; $display("[TB] FAIL drain_ready got=%b exp=1", disp_ready); end
    endtask

    task automatic test_oldest_first();
        au_ready = 1'b1;
        set_disp(5'd3, 4'd1, 1'b0, 4'd2, 32'd0, 1'b1, 4'd0, 32'd4);
        tick();
        set_disp(5'd4, 4'd7, 1'b1, 4'd0, 32'h11, 1'b1, 4'd0, 32'h22);
        tick();
        idle_inputs();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL oldest_none got=%b exp=0", issue_valid); end
        tick();
        total++; if (issue_valid !== 1'b1 || issue_tag !== 4'd7 || operand1 !== 32'h11) begin bad++; $display("[TB] FAIL oldest_young_first got=%b/%h/%h exp=1/7/11", issue_valid, issue_tag, operand1); end
        cdb_valid = 1'b1;
        cdb_tag   = 4'd2;
        cdb_data  = 32'h77;
        tick();
        idle_inputs();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL oldest_gap got=%b exp=0", issue_valid); end
        tick();
        total++; if (issue_valid !== 1'b1 || issue_tag !== 4'd1 || operand1 !== 32'h77 || operand2 !== 32'd4) begin
            bad++; $display("[TB] FAIL oldest_old_next got=%b/%h/%h/%h exp=1/1/77/4", issue_valid, issue_tag, operand1, operand2);
        end
        tick();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL oldest_drain got=%b exp=0", issue_valid); end
    endtask

    task automatic test_forwarding();
        au_ready = 1'b1;
        set_disp(5'd5, 4'd8, 1'b1, 4'd0, 32'h3, 1'b0, 4'd4, 32'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd4;
        cdb_data  = 32'h55;
        tick();
        idle_inputs();
        tick();
        total++; if (issue_valid !== 1'b1 || operand1 !== 32'h3 || operand2 !== 32'h55 || issue_tag !== 4'd8) begin
            bad++; $display("[TB] FAIL fwd_issue got=%b/%h/%h/%h exp=1/3/55/8", issue_valid, operand1, operand2, issue_tag);
        end
        tick();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL fwd_drain got=%b exp=0", issue_valid); end
    endtask

    task automatic test_flush();
        au_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_disp(5'd2, 4'(k + 10), 1'b1, 4'd0, 32'(100 + k), 1'b1, 4'd0, 32'd1);
            tick();
        end
        idle_inputs();
        total++; if (issue_valid !== 1'b1 || disp_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_pre got=%b/%b exp=1/1", issue_valid, disp_ready); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (issue_valid !== 1'b0 || disp_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_clear got=%b/%b exp=0/1", issue_valid, disp_ready); end
        au_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_stale_%0d got=%b/%h exp=0", k, issue_valid, operand1); end
        end
    endtask

    task automatic test_async_reset();
        au_ready = 1'b1;
        set_disp(5'd6, 4'd5, 1'b1, 4'd0, 32'h123, 1'b1, 4'd0, 32'h456);
        tick();
        set_disp(5'd6, 4'd6, 1'b1, 4'd0, 32'h124, 1'b1, 4'd0, 32'h457);
        tick();
        idle_inputs();
        au_ready = 1'b0;
        total++; if (issue_valid !== 1'b1 || operand1 !== 32'h123) begin bad++; $display("[TB] FAIL arst_pre got=%b/%h exp=1/123", issue_valid, operand1); end
        #3;
        rst = 1'b1;
        #1;
        total++; if (issue_valid !== 1'b0 || operand1 !== 32'd0 || operand2 !== 32'd0 || issue_tag !== 4'd0 || execute_type !== 5'd0) begin
            bad++; $display("[TB] FAIL arst_immediate got=%b/%h/%h/%h/%h exp=0/0/0/0/0", issue_valid, operand1, operand2, issue_tag, execute_type);
        end
        total++; if (disp_ready !== 1'b1) begin bad++; $display("[TB] FAIL arst_ready got=%b exp=1", disp_ready); end
        tick();
        rst = 1'b0;
        au_ready = 1'b1;
        tick();
        tick();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL arst_no_stale got=%b exp=0", issue_valid); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_ready_dispatch();
        test_cdb_wakeup();
        test_full_backpressure();
        test_oldest_first();
        test_forwarding();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
